// File: rtl/mac_mul_block_pipe.sv
// mac_mul_block_pipe: pipelined multiplier with selectable lane configuration.
// cfg 00 = A2*B2, 01 = {A3,A2}*B2 (both unsigned), 10 = signed {A3..A0}*B2,
// and 11 is an illegal op that still flows through, giving C=0 and err=1.
// Stage 1 registers the four lane products. The middle stages pass them on.
// The shifted sum is formed while loading the output register, so the final
// addition completes in the last stage.
//
// Handshake: an input is accepted on a rising edge when in_valid & in_ready.
// A result is transferred when en & out_valid & out_ready. in_ready depends
// only on en, rst and pipeline state, never on in_valid. While a result waits
// (out_valid=1, out_ready=0) or en=0, C/cfg_out/err and every stage hold. The
// one exception is an empty stage 1, which may still take a new op.
module mac_mul_block_pipe #(
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_CONF_WIDTH = 2,
  parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH,
  parameter int PIPE_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MAC_MIN_WIDTH-1:0]  B2,
  input  logic [MAC_MIN_WIDTH-1:0]  A0,
  input  logic [MAC_MIN_WIDTH-1:0]  A1,
  input  logic [MAC_MIN_WIDTH-1:0]  A2,
  input  logic [MAC_MIN_WIDTH-1:0]  A3,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MAC_INT_WIDTH-1:0]  C,
  output logic [MAC_CONF_WIDTH-1:0] cfg_out,
  output logic                      err,
  output logic [15:0]               op_count
);

  localparam int W  = MAC_MIN_WIDTH;
  localparam int CW = MAC_CONF_WIDTH;
  localparam int R  = MAC_INT_WIDTH;
  // Each lane product is a signed (W+1) x (W+1) product; 2W+2 bits hold it.
  localparam int PW = 2 * W + 2;

  // Combine the lane products for the given configuration.
  function automatic logic [R-1:0] f_combine(input logic [PW-1:0] p0,
                                             input logic [PW-1:0] p1,
                                             input logic [PW-1:0] p2,
                                             input logic [PW-1:0] p3,
                                             input logic [CW-1:0] c);
    logic [R-1:0] s0;
    logic [R-1:0] s1;
    logic [R-1:0] s2;
    logic [R-1:0] s3;
    logic [R-1:0] res;
    s0 = {{(R-PW){p0[PW-1]}}, p0};
    s1 = {{(R-PW){p1[PW-1]}}, p1};
    s2 = {{(R-PW){p2[PW-1]}}, p2};
    s3 = {{(R-PW){p3[PW-1]}}, p3};
    res = '0;
    if (c == CW'(0)) begin
      res = s2;
    end else if (c == CW'(1)) begin
      res = s2 + (s3 << W);
    end else if (c == CW'(2)) begin
      res = s0 + (s1 << W) + (s2 << (2 * W)) + (s3 << (3 * W));
    end
    return res;
  endfunction

  logic [W-1:0]           w_lane [4];
  logic [PW-1:0]          w_pp   [4];
  logic                   w_quad;
  logic                   w_adv;
  logic                   w_acc;
  logic [R-1:0]           w_fin_c;
  logic [CW-1:0]          w_fin_cfg;
  logic [PIPE_STAGES-1:0] r_vld;

  assign w_lane[0] = A0;
  assign w_lane[1] = A1;
  assign w_lane[2] = A2;
  assign w_lane[3] = A3;
  assign w_quad    = (cfg == CW'(2));

  // Lane products. Quad mode treats B2 and the top lane as signed.
  always_comb begin
    logic [PW-1:0] v_a;
    logic [PW-1:0] v_b;
    v_b = {{(PW-W){w_quad & B2[W-1]}}, B2};
    v_a = '0;
    for (int i = 0; i < 4; i++) begin
      v_a = {{(PW-W){w_quad && (i == 3) && w_lane[i][W-1]}}, w_lane[i]};
      w_pp[i] = v_a * v_b;
    end
  end

  assign w_adv     = en & (~out_valid | out_ready);
  assign in_ready  = rst & en & (~r_vld[0] | w_adv);
  assign w_acc     = in_valid & in_ready;
  assign out_valid = r_vld[PIPE_STAGES-1];

  // Valid chain: shift on advance, otherwise only an empty stage 1 fills.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld[0] <= w_acc;
      for (int k = 1; k < PIPE_STAGES; k++) r_vld[k] <= r_vld[k-1];
    end else if (w_acc) begin
      r_vld[0] <= 1'b1;
    end
  end

  generate
    if (PIPE_STAGES == 1) begin : g_one
      assign w_fin_c   = f_combine(w_pp[0], w_pp[1], w_pp[2], w_pp[3], cfg);
      assign w_fin_cfg = cfg;
    end else begin : g_multi
      logic [PW-1:0] r_pp  [PIPE_STAGES-1][4];
      logic [CW-1:0] r_cfg [PIPE_STAGES-1];

      // Partial-product stages: stage 1 loads on accept, the rest shift.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < PIPE_STAGES - 1; s++) begin
            r_cfg[s] <= '0;
            for (int i = 0; i < 4; i++) r_pp[s][i] <= '0;
          end
        end else begin
          if (w_acc) begin
            r_cfg[0] <= cfg;
            for (int i = 0; i < 4; i++) r_pp[0][i] <= w_pp[i];
          end
          if (w_adv) begin
            for (int s = 1; s < PIPE_STAGES - 1; s++) begin
              r_cfg[s] <= r_cfg[s-1];
              for (int i = 0; i < 4; i++) r_pp[s][i] <= r_pp[s-1][i];
            end
          end
        end
      end

      assign w_fin_c   = f_combine(r_pp[PIPE_STAGES-2][0], r_pp[PIPE_STAGES-2][1],
                                   r_pp[PIPE_STAGES-2][2], r_pp[PIPE_STAGES-2][3],
                                   r_cfg[PIPE_STAGES-2]);
      assign w_fin_cfg = r_cfg[PIPE_STAGES-2];
    end
  endgenerate

  // Output stage: final sum, captured cfg and illegal flag move together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      C       <= '0;
      cfg_out <= '0;
      err     <= 1'b0;
    end else if (w_adv) begin
      C       <= w_fin_c;
      cfg_out <= w_fin_cfg;
      err     <= (w_fin_cfg > CW'(2));
    end
  end

  // Saturating count of results taken downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_count <= '0;
    end else if (en && out_valid && out_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mac_mul_block_pipe.sv
// Directed bench for mac_mul_block_pipe (W=8, R=40, PIPE_STAGES=2).
module tb_mac_mul_block_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  B2 = '0;
  logic [7:0]  A0 = '0;
  logic [7:0]  A1 = '0;
  logic [7:0]  A2 = '0;
  logic [7:0]  A3 = '0;
  logic [1:0]  cfg = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [39:0] C;
  logic [1:0]  cfg_out;
  logic        err;
  logic [15:0] op_count;

  int total = 0;
  int bad = 0;

  // Stream description shared by run_stream.
  int          n_ops;
  logic [1:0]  s_cfg [8];
  logic [31:0] s_a   [8];
  logic [7:0]  s_b   [8];
  logic [39:0] s_c   [8];
  logic        s_err [8];
  int          stall_lo, stall_hi, en_lo, en_hi;

  mac_mul_block_pipe dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .B2(B2), .A0(A0), .A1(A1), .A2(A2), .A3(A3), .cfg(cfg),
    .out_valid(out_valid), .out_ready(out_ready), .C(C), .cfg_out(cfg_out),
    .err(err), .op_count(op_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] c, input logic [31:0] a, input logic [7:0] b);
    cfg = c;
    {A3, A2, A1, A0} = a;
    B2 = b;
  endtask

  // One op through an empty pipeline with out_ready=1.
  task automatic run_single(input string tag, input logic [1:0] c, input logic [31:0] a,
                            input logic [7:0] b, input logic [39:0] exp_c, input logic exp_err);
    set_in(c, a, b);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, " valid_early"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, " C"}, 64'(C), 64'(exp_c));
    chk({tag, " err"}, 64'(err), 64'(exp_err));
    chk({tag, " cfg_out"}, 64'(cfg_out), 64'(c));
    tick();
    chk({tag, " drained"}, 64'(out_valid), 64'd0);
  endtask

  // Stream n_ops ops with scheduled out_ready and en gaps; scoreboard order.
  task automatic run_stream(input string tag);
    logic [39:0] exp_q[$];
    logic        exp_err_q[$];
    logic [1:0]  exp_cfg_q[$];
    int sent = 0;
    int got = 0;
    for (int cyc = 0; cyc < 40 && got < n_ops; cyc++) begin
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      en        = !(cyc >= en_lo && cyc <= en_hi);
      in_valid  = (sent < n_ops);
      if (sent < n_ops) set_in(s_cfg[sent], s_a[sent], s_b[sent]);
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk({tag, " unexpected_result"}, 64'd1, 64'd0);
        end else if (out_ready && en) begin
          chk({tag, " C"}, 64'(C), 64'(exp_q.pop_front()));
          chk({tag, " err"}, 64'(err), 64'(exp_err_q.pop_front()));
          chk({tag, " cfg_out"}, 64'(cfg_out), 64'(exp_cfg_q.pop_front()));
          got++;
        end else begin
          chk({tag, " C_hold"}, 64'(C), 64'(exp_q[0]));
          chk({tag, " err_hold"}, 64'(err), 64'(exp_err_q[0]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(s_c[sent]);
        exp_err_q.push_back(s_err[sent]);
        exp_cfg_q.push_back(s_cfg[sent]);
        sent++;
      end
      tick();
    end
    in_valid  = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    chk({tag, " results"}, 64'(got), 64'(n_ops));
    chk({tag, " leftover"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // reset state
    #1 rst = 1'b0;
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst C", 64'(C), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst op_count", 64'(op_count), 64'd0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // five ops back-to-back, out_ready low for cycles 3..6
    n_ops = 5;
    s_cfg[0] = 2'b00; s_a[0] = 32'h0011_0000; s_b[0] = 8'h11; s_c[0] = 40'h0000000121; s_err[0] = 1'b0;
    s_cfg[1] = 2'b01; s_a[1] = 32'h0100_0000; s_b[1] = 8'h03; s_c[1] = 40'h0000000300; s_err[1] = 1'b0;
    s_cfg[2] = 2'b10; s_a[2] = 32'hFFFF_FFFE; s_b[2] = 8'h03; s_c[2] = 40'hFFFFFFFFFA; s_err[2] = 1'b0;
    s_cfg[3] = 2'b00; s_a[3] = 32'h0080_0000; s_b[3] = 8'h02; s_c[3] = 40'h0000000100; s_err[3] = 1'b0;
    s_cfg[4] = 2'b10; s_a[4] = 32'h0000_0010; s_b[4] = 8'h7F; s_c[4] = 40'h00000007F0; s_err[4] = 1'b0;
    stall_lo = 3; stall_hi = 6; en_lo = 100; en_hi = -1;
    run_stream("stall_stream");
    chk("stream op_count", 64'(op_count), 64'd5);

    // single ops
    run_single("single_ff", 2'b00, 32'h00FF_0000, 8'hFF, 40'h000000FE01, 1'b0);
    chk("op_count after single", 64'(op_count), 64'd6);
    run_single("dual_1234", 2'b01, 32'h1234_0000, 8'h10, 40'h0000012340, 1'b0);
    run_single("quad_m1", 2'b10, 32'hFFFF_FFFF, 8'h80, 40'h0000000080, 1'b0);
    run_single("quad_min", 2'b10, 32'h8000_0000, 8'h80, 40'h4000000000, 1'b0);
    run_single("quad_neg", 2'b10, 32'h0000_0003, 8'hFF, 40'hFFFFFFFFFD, 1'b0);
    run_single("single_lane", 2'b00, 32'h120A_3456, 8'h0C, 40'h0000000078, 1'b0);
    run_single("dual_max", 2'b01, 32'hFFFF_1234, 8'hFF, 40'h0000FEFF01, 1'b0);
    chk("op_count after singles", 64'(op_count), 64'd12);

    // illegal op between legal ops, with an en=0 gap
    n_ops = 3;
    s_cfg[0] = 2'b00; s_a[0] = 32'h0003_0000; s_b[0] = 8'h05; s_c[0] = 40'h000000000F; s_err[0] = 1'b0;
    s_cfg[1] = 2'b11; s_a[1] = 32'h1234_5678; s_b[1] = 8'h9A; s_c[1] = 40'h0000000000; s_err[1] = 1'b1;
    s_cfg[2] = 2'b01; s_a[2] = 32'h0102_0000; s_b[2] = 8'h02; s_c[2] = 40'h0000000204; s_err[2] = 1'b0;
    stall_lo = 100; stall_hi = -1; en_lo = 2; en_hi = 3;
    run_stream("illegal_stream");
    chk("op_count after illegal", 64'(op_count), 64'd15);

    // reset with two ops in flight
    out_ready = 1'b0;
    set_in(2'b00, 32'h0002_0000, 8'h02);
    in_valid = 1'b1;
    tick();
    set_in(2'b00, 32'h0003_0000, 8'h03);
    tick();
    in_valid = 1'b0;
    chk("inflight out_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async op_count", 64'(op_count), 64'd0);
    chk("async in_ready", 64'(in_ready), 64'd0);
    chk("async C", 64'(C), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_single("post_reset", 2'b00, 32'h0007_0000, 8'h06, 40'h000000002A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale", 64'(out_valid), 64'd0);
    end
    chk("post_reset op_count", 64'(op_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_mul_block_pipe.md
MAC_MUL_BLOCK_PIPE -- requirements
Module: mac_mul_block_pipe

Interface
REQ-001 Parameter MAC_MIN_WIDTH, default 8: lane width W in bits.
REQ-002 Parameter MAC_CONF_WIDTH, default 2: width of the cfg port.
REQ-003 Parameter MAC_INT_WIDTH, default 5*MAC_MIN_WIDTH: result width R.
REQ-004 Parameter PIPE_STAGES, default 2, legal range 1..4: number of register stages from input accept to result valid.
REQ-005 Ports (name, direction, width, meaning):
  - clk  in  1: single clock; all flops rise-edge.
  - rst  in  1: asynchronous, active-low reset.
  - en  in  1: global enable; 0 freezes the pipeline.
  - in_valid  in  1: input operands valid.
  - in_ready  out  1: block can accept this cycle.
  - B2  in  W: multiplier operand.
  - A0, A1, A2, A3  in  W each: multiplicand lanes, A0 least significant.
  - cfg  in  MAC_CONF_WIDTH: 00 single, 01 dual, 10 quad, 11 illegal.
  - out_valid  out  1: C valid.
  - out_ready  in  1: downstream accepts C.
  - C  out  R: registered product.
  - cfg_out  out  MAC_CONF_WIDTH: cfg captured with this result.
  - err  out  1: result came from illegal cfg.
  - op_count  out  16: number of results accepted downstream.

Function
REQ-006 Accept occurs on a rising edge with in_valid & in_ready; output transfer occurs with out_valid & out_ready.
REQ-007 in_ready = en & (stage 1 empty, or the pipeline advances this cycle); in_ready has no combinational path from in_valid.
REQ-008 Pipeline advances when en=1 and (out_valid=0 or out_ready=1); otherwise every stage, including its valid bit, holds.
REQ-009 Each stage carries valid, cfg and partial results; bubbles collapse, so throughput is one op per cycle with no backpressure.
REQ-010 Latency is exactly PIPE_STAGES cycles from accept to out_valid when unstalled; each stall cycle adds one cycle.
REQ-011 Single (00) computes C = zero-extend(A2*B2), unsigned, 2W significant bits; upper bits are 0.
REQ-012 Dual (01) computes C = zero-extend({A3,A2}*B2), unsigned, 3W significant bits; upper bits are 0.
REQ-013 Quad (10) computes C = {A3,A2,A1,A0}*B2 as a signed 4W x signed W two's-complement product, exactly R bits, no truncation.
REQ-014 Illegal cfg (11): the op flows through normally; C = 0, err = 1 with that result, and err = 0 otherwise.
REQ-015 The partial products are the four W x W lane products, combined with shifted carry-propagating additions; the final addition completes in the last stage.
REQ-016 C, cfg_out and err hold stable while out_valid=1 and out_ready=0.
REQ-017 op_count increments by 1 on each output transfer and saturates at 16'hFFFF, with no wrap.
REQ-018 Changing cfg between consecutive accepts is legal; each op uses its own captured cfg.
REQ-019 en=0 blocks accept and output transfer; out_valid keeps its value; there is no data loss.

Reset
REQ-020 When rst=0, asynchronously clear all stage valid bits, out_valid, C, cfg_out, err and op_count to 0.
REQ-021 in_ready = 0 while rst=0; in-flight ops are discarded and not replayed.
REQ-022 Deassertion of rst is synchronised externally; the first accept is permitted on the first edge after release.

Verification
REQ-023 PIPE_STAGES=2, cfg=00, A2=8'hFF, B2=8'hFF, out_ready=1 -> out_valid after 2 cycles, C=40'h000000FE01, err=0.
REQ-024 cfg=01, A3=8'h12, A2=8'h34, B2=8'h10 -> C=40'h0000012340.
REQ-025 cfg=10, {A3..A0}=32'hFFFFFFFF (-1), B2=8'h80 (-128) -> C=40'h0000000080; also 32'h80000000 x 8'h80 -> C=40'h4000000000.
REQ-026 Stream 5 ops back-to-back with out_ready=0 for cycles 3-6 -> all 5 results in order, none dropped or duplicated, and C stable while stalled; op_count=5 at the end.
REQ-027 cfg=11 op between two legal ops -> that result has C=0 and err=1, and neighbouring ops are unaffected.
REQ-028 Assert rst mid-stream with 2 ops in flight -> out_valid=0, op_count=0 immediately without waiting for a clock edge, and no stale result after release.
